// File: rtl/square_ctl_pkg.sv
// Shared types and geometry constants for the square overlay controller.
package square_ctl_pkg;

  localparam int unsigned CW         = 12;
  localparam int unsigned HOR_PIXELS = 800;
  localparam int unsigned VER_PIXELS = 600;
  localparam int unsigned SQ_H       = 8;
  localparam int unsigned STEP       = 4;
  localparam int unsigned W_STEP     = 8;
  localparam int unsigned MIN_W      = 8;
  localparam int unsigned MAX_W      = 128;
  localparam int unsigned INIT_X     = 150;
  localparam int unsigned INIT_Y     = 100;
  localparam int unsigned INIT_W     = 32;

  typedef enum logic [2:0] {
    CMD_NOP    = 3'd0,
    CMD_LEFT   = 3'd1,
    CMD_RIGHT  = 3'd2,
    CMD_UP     = 3'd3,
    CMD_DOWN   = 3'd4,
    CMD_GROW   = 3'd5,
    CMD_SHRINK = 3'd6,
    CMD_CENTER = 3'd7
  } cmd_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  // Square placement as seen by the draw stage.
  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [CW-1:0] w;
  } sq_geom_t;

endpackage

// File: rtl/square_ctl_arb.sv
// Two-way round-robin arbiter; the priority pointer moves only when a grant is issued.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  // Requester that wins when both request.
  logic prio_q;
  logic prio_d;

  always_comb begin
    grant  = 2'b00;
    prio_d = prio_q;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
      if (grant != 2'b00) begin
        prio_d = grant[0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/square_ctl.sv
// Frame-synchronous square move/resize controller: arbitrates two command sources
// and applies one command per frame at the start of vertical blank, with clamping.
module square_ctl
  import square_ctl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            vblnk,
  input  logic [1:0]      req_valid,
  input  cmd_t [1:0]      req_cmd,
  output logic [1:0]      req_ready,
  output logic [CW-1:0]   xpos_square,
  output logic [CW-1:0]   ypos_square,
  output logic [CW-1:0]   width_square,
  output logic            busy,
  output logic            applied
);

  localparam logic [CW-1:0] C_STEP   = CW'(STEP);
  localparam logic [CW-1:0] C_WSTEP  = CW'(W_STEP);
  localparam logic [CW-1:0] C_MIN_W  = CW'(MIN_W);
  localparam logic [CW-1:0] C_MAX_W  = CW'(MAX_W);
  localparam logic [CW-1:0] C_X_LIM  = CW'(HOR_PIXELS - 1);
  localparam logic [CW-1:0] C_Y_MAX  = CW'(VER_PIXELS - 1 - SQ_H);
  localparam sq_geom_t      GEOM_RST = '{x: CW'(INIT_X), y: CW'(INIT_Y), w: CW'(INIT_W)};

  state_t   state_q, state_d;
  cmd_t     cmd_q, cmd_d;
  sq_geom_t geom_q, geom_d, geom_nxt;
  logic     vblnk_q;
  logic     busy_q, busy_d;
  logic     applied_q, applied_d;
  logic     arb_en;
  logic     vblank_rise;
  logic [1:0] grant;

  logic [CW-1:0] x_max;
  logic [CW-1:0] sum_x, sum_y;
  logic [CW-1:0] w_grow, w_shrink, x_lim_grow;

  assign vblank_rise = vblnk & ~vblnk_q;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req_valid),
    .en    (arb_en),
    .grant (grant)
  );

  assign req_ready = grant;

  // Clamped geometry that the latched command would produce.
  always_comb begin
    geom_nxt   = geom_q;
    x_max      = C_X_LIM - geom_q.w;
    sum_x      = geom_q.x + C_STEP;
    sum_y      = geom_q.y + C_STEP;
    w_grow     = ((geom_q.w + C_WSTEP) > C_MAX_W) ? C_MAX_W : (geom_q.w + C_WSTEP);
    w_shrink   = (geom_q.w >= (C_MIN_W + C_WSTEP)) ? (geom_q.w - C_WSTEP) : C_MIN_W;
    x_lim_grow = C_X_LIM - w_grow;
    case (cmd_q)
      CMD_LEFT:   geom_nxt.x = (geom_q.x >= C_STEP) ? (geom_q.x - C_STEP) : '0;
      CMD_RIGHT:  geom_nxt.x = (sum_x > x_max) ? x_max : sum_x;
      CMD_UP:     geom_nxt.y = (geom_q.y >= C_STEP) ? (geom_q.y - C_STEP) : '0;
      CMD_DOWN:   geom_nxt.y = (sum_y > C_Y_MAX) ? C_Y_MAX : sum_y;
      CMD_GROW: begin
        geom_nxt.w = w_grow;
        geom_nxt.x = (geom_q.x > x_lim_grow) ? x_lim_grow : geom_q.x;
      end
      CMD_SHRINK: geom_nxt.w = w_shrink;
      CMD_CENTER: begin
        geom_nxt.x = x_max >> 1;
        geom_nxt.y = C_Y_MAX >> 1;
      end
      default:    geom_nxt = geom_q;
    endcase
  end

  // Accept one command while idle; commit it on the first vblank rise afterwards.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    geom_d    = geom_q;
    applied_d = 1'b0;
    arb_en    = 1'b0;
    case (state_q)
      IDLE: begin
        arb_en = ~rst;
        if (grant[0]) begin
          cmd_d   = req_cmd[0];
          state_d = PENDING;
        end else if (grant[1]) begin
          cmd_d   = req_cmd[1];
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (vblank_rise) begin
          geom_d    = geom_nxt;
          applied_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == PENDING);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cmd_q     <= CMD_NOP;
      geom_q    <= GEOM_RST;
      vblnk_q   <= 1'b0;
      busy_q    <= 1'b0;
      applied_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      geom_q    <= geom_d;
      vblnk_q   <= vblnk;
      busy_q    <= busy_d;
      applied_q <= applied_d;
    end
  end

  assign xpos_square  = geom_q.x;
  assign ypos_square  = geom_q.y;
  assign width_square = geom_q.w;
  assign busy         = busy_q;
  assign applied      = applied_q;

endmodule

// File: tb/tb_square_ctl.sv
// Scoreboard bench for square_ctl: stimulus queues expected grants and geometry,
// a negedge monitor compares on every handshake and every applied pulse.
module tb_square_ctl;
  import square_ctl_pkg::*;

  logic        clk;
  logic        rst;
  logic        vblnk;
  logic [1:0]  req_valid;
  cmd_t [1:0]  req_cmd;
  logic [1:0]  req_ready;
  logic [11:0] xpos_square, ypos_square, width_square;
  logic        busy, applied;

  square_ctl dut (
    .clk          (clk),
    .rst          (rst),
    .vblnk        (vblnk),
    .req_valid    (req_valid),
    .req_cmd      (req_cmd),
    .req_ready    (req_ready),
    .xpos_square  (xpos_square),
    .ypos_square  (ypos_square),
    .width_square (width_square),
    .busy         (busy),
    .applied      (applied)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {int x; int y; int w;} exp_t;

  exp_t exp_q[$];
  int   grant_q[$];
  int   total = 0;
  int   bad = 0;
  int   apply_cnt = 0;
  int   mx, my, mw;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: grants, applied updates, and output stability between updates.
  logic [11:0] px, py, pw;
  bit          have_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      chk("ready_without_valid", int'(req_ready & ~req_valid), 0);
      if (busy) chk("ready_while_busy", int'(req_ready), 0);
      if ((req_ready & req_valid) != 2'b00) begin
        if (grant_q.size() == 0) begin
          chk("unexpected_grant", int'(req_ready), 0);
        end else begin
          int g;
          g = grant_q.pop_front();
          chk("grant", int'(req_ready), 1 << g);
        end
      end
      if (applied) begin
        apply_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_applied", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("applied_x", int'(xpos_square), e.x);
          chk("applied_y", int'(ypos_square), e.y);
          chk("applied_w", int'(width_square), e.w);
        end
      end else if (have_prev) begin
        chk("hold_x", int'(xpos_square), int'(px));
        chk("hold_y", int'(ypos_square), int'(py));
        chk("hold_w", int'(width_square), int'(pw));
      end
    end
    px = xpos_square;
    py = ypos_square;
    pw = width_square;
    have_prev = !rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mx = 150; my = 100; mw = 32;
  endtask

  task automatic model_apply(input cmd_t c);
    case (c)
      CMD_LEFT:   mx = (mx >= 4) ? mx - 4 : 0;
      CMD_RIGHT:  mx = (mx + 4 > 799 - mw) ? 799 - mw : mx + 4;
      CMD_UP:     my = (my >= 4) ? my - 4 : 0;
      CMD_DOWN:   my = (my + 4 > 591) ? 591 : my + 4;
      CMD_GROW: begin
        mw = (mw + 8 > 128) ? 128 : mw + 8;
        if (mx > 799 - mw) mx = 799 - mw;
      end
      CMD_SHRINK: mw = (mw - 8 < 8) ? 8 : mw - 8;
      CMD_CENTER: begin
        mx = (799 - mw) / 2;
        my = 591 / 2;
      end
      default: ;
    endcase
  endtask

  task automatic push_cmd(input int r, input cmd_t c);
    exp_t e;
    grant_q.push_back(r);
    model_apply(c);
    e.x = mx; e.y = my; e.w = mw;
    exp_q.push_back(e);
  endtask

  task automatic wait_busy(input bit level);
    int n = 0;
    while (busy !== level && n < 30) begin
      tick();
      n++;
    end
    chk("busy_wait", int'(busy), int'(level));
  endtask

  task automatic vpulse();
    vblnk = 1'b1;
    repeat (3) tick();
    vblnk = 1'b0;
    repeat (2) tick();
  endtask

  task automatic handshake(input int r, input cmd_t c);
    req_cmd[r]   = c;
    req_valid[r] = 1'b1;
    wait_busy(1'b1);
    req_valid[r] = 1'b0;
  endtask

  task automatic issue(input int r, input cmd_t c);
    push_cmd(r, c);
    handshake(r, c);
    vpulse();
    wait_busy(1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic chk_geom(input string name, input int x, input int y, input int w);
    chk({name, "_x"}, int'(xpos_square), x);
    chk({name, "_y"}, int'(ypos_square), y);
    chk({name, "_w"}, int'(width_square), w);
  endtask

  initial begin
    int a0;
    rst       = 1'b1;
    vblnk     = 1'b0;
    req_valid = 2'b00;
    req_cmd   = {CMD_NOP, CMD_NOP};
    model_reset();

    // Reset state; no grant while reset is held even with requests present.
    tick();
    req_valid = 2'b11;
    tick(); tick();
    chk("ready_in_reset", int'(req_ready), 0);
    req_valid = 2'b00;
    rst = 1'b0;
    tick();
    chk_geom("reset", 150, 100, 32);
    chk("reset_busy", int'(busy), 0);
    chk("reset_applied", int'(applied), 0);
    chk("reset_ready", int'(req_ready), 0);

    // Pending command dropped by reset.
    grant_q.push_back(0);
    handshake(0, CMD_RIGHT);
    a0 = apply_cnt;
    do_reset();
    chk("drop_busy", int'(busy), 0);
    vpulse();
    chk_geom("drop", 150, 100, 32);
    chk("drop_no_apply", apply_cnt, a0);

    // Both requesters valid for three frames: grants 0,1,0.
    push_cmd(0, CMD_RIGHT);
    push_cmd(1, CMD_DOWN);
    push_cmd(0, CMD_RIGHT);
    req_cmd   = {CMD_DOWN, CMD_RIGHT};
    req_valid = 2'b11;
    for (int f = 0; f < 3; f++) begin
      wait_busy(1'b1);
      if (f == 2) req_valid = 2'b00;
      vpulse();
    end
    wait_busy(1'b0);
    chk_geom("rr", 158, 104, 32);

    // Single move, applied pulse right at the rise edge and only for one cycle.
    do_reset();
    push_cmd(0, CMD_RIGHT);
    handshake(0, CMD_RIGHT);
    repeat (3) tick();
    chk("pre_rise_x", int'(xpos_square), 150);
    vblnk = 1'b1;
    tick();
    chk("rise_applied", int'(applied), 1);
    chk("rise_x", int'(xpos_square), 154);
    tick();
    chk("applied_one_cycle", int'(applied), 0);
    vblnk = 1'b0;
    repeat (2) tick();

    // Right edge clamp with w=32.
    for (int i = 0; i < 153; i++) issue(0, CMD_RIGHT);
    chk("x_766", int'(xpos_square), 766);
    issue(0, CMD_RIGHT);
    chk("x_clamp", int'(xpos_square), 767);
    issue(1, CMD_RIGHT);
    chk("x_stay", int'(xpos_square), 767);

    // Bottom clamp.
    for (int i = 0; i < 122; i++) issue(i % 2, CMD_DOWN);
    chk("y_588", int'(ypos_square), 588);
    issue(0, CMD_DOWN);
    chk("y_clamp", int'(ypos_square), 591);
    issue(0, CMD_DOWN);
    chk("y_stay", int'(ypos_square), 591);

    issue(1, CMD_CENTER);
    chk_geom("center", 383, 295, 32);
    issue(0, CMD_NOP);
    chk_geom("nop", 383, 295, 32);

    // Width limits.
    for (int i = 0; i < 12; i++) issue(0, CMD_GROW);
    chk("w_128", int'(width_square), 128);
    issue(0, CMD_GROW);
    chk("w_max_stay", int'(width_square), 128);
    for (int i = 0; i < 15; i++) issue(1, CMD_SHRINK);
    chk("w_8", int'(width_square), 8);
    issue(1, CMD_SHRINK);
    chk("w_min_stay", int'(width_square), 8);
    chk("shrink_x", int'(xpos_square), 383);

    // Left floor from x=2, then GROW pulling x back inside the screen.
    do_reset();
    for (int i = 0; i < 37; i++) issue(0, CMD_LEFT);
    chk("x_2", int'(xpos_square), 2);
    issue(0, CMD_LEFT);
    chk("x_floor", int'(xpos_square), 0);
    for (int i = 0; i < 8; i++) issue(0, CMD_GROW);
    for (int i = 0; i < 175; i++) issue(1, CMD_RIGHT);
    chk_geom("pre_grow", 700, 100, 96);
    issue(0, CMD_GROW);
    chk_geom("grow_clamp", 695, 100, 104);
    issue(0, CMD_UP);
    chk("y_up", int'(ypos_square), 96);

    // Accepted on the same cycle as the rise: waits for the next frame.
    push_cmd(0, CMD_LEFT);
    a0 = apply_cnt;
    req_cmd[0]   = CMD_LEFT;
    req_valid[0] = 1'b1;
    vblnk        = 1'b1;
    tick();
    chk("same_cycle_busy", int'(busy), 1);
    req_valid[0] = 1'b0;
    repeat (2) tick();
    vblnk = 1'b0;
    repeat (3) tick();
    chk("same_cycle_no_apply", apply_cnt, a0);
    chk("same_cycle_x", int'(xpos_square), 695);
    chk("same_cycle_still_busy", int'(busy), 1);
    vpulse();
    wait_busy(1'b0);
    chk("next_frame_apply", apply_cnt, a0 + 1);
    chk("next_frame_x", int'(xpos_square), 691);

    repeat (3) tick();
    chk("exp_q_empty", exp_q.size(), 0);
    chk("grant_q_empty", grant_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
